jesd_tx_link: RTL and testbench

//  JESD204B-style TX link layer; sits directly downstream of the sample-to-JESD adapter (tx).

---
 rtl/jesd_tx_link.sv | 173 +++++++++++++++++
 tb/tb_jesd_tx_link.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/jesd_tx_link.sv
// JESD204B-style TX link layer: sequences RST -> CGS -> ILAS -> DATA and drives the
// PHY lane with K28.5 / ILAS multiframes / payload-or-fill, gated by the receiver SYNC~.
module jesd_tx_link #(
    parameter int P            = 32,
    parameter int CGS_CYCLES   = 12,
    parameter int BEATS_PER_MF = 5,
    parameter int ILAS_MF      = 4,
    parameter int SYNC_LOSS    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jesd_tx_rst_n,
    input  logic             jesd_tx_en,
    output logic             jesd_cgs_done,
    output logic             jesd_ilas_done,
    output logic             jesd_link_up,
    input  logic             jesd_tx_val,
    output logic             jesd_tx_rdy,
    input  logic [P-1:0]     jesd_tx_dat,
    input  logic             sync_n,
    output logic             phy_val,
    input  logic             phy_rdy,
    output logic [P-1:0]     phy_dat,
    output logic [P/8-1:0]   phy_k
);
    // state | meaning
    // RST   | link held in reset, lane idle
    // CGS   | code-group sync, lane carries K28.5
    // ILAS  | initial lane alignment multiframes
    // DATA  | payload transfer, fill when idle or SYNC~ dropped

    localparam int NB   = P / 8;
    localparam int ILAS = BEATS_PER_MF * ILAS_MF;
    localparam int CW   = $clog2(CGS_CYCLES + 1);
    localparam int IW   = $clog2(ILAS + 1);
    localparam int MW   = $clog2(BEATS_PER_MF + 1);
    localparam int LW   = $clog2(SYNC_LOSS + 1);

    localparam logic [CW-1:0] CGS_LAST  = CW'(CGS_CYCLES - 1);
    localparam logic [IW-1:0] ILAS_LAST = IW'(ILAS - 1);
    localparam logic [MW-1:0] MF_LAST   = MW'(BEATS_PER_MF - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(SYNC_LOSS - 1);

    typedef enum logic [1:0] {ST_RST, ST_CGS, ST_ILAS, ST_DATA} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cgs_cnt;
    logic [IW-1:0]   r_ilas_cnt;
    logic [MW-1:0]   r_mf_pos;
    logic [LW-1:0]   r_loss_cnt;
    logic            r_cgs_done;
    logic            r_ilas_done;
    logic            r_link_up;

    assign jesd_cgs_done  = r_cgs_done;
    assign jesd_ilas_done = r_ilas_done;
    assign jesd_link_up   = r_link_up;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RST;
            r_cgs_cnt   <= '0;
            r_ilas_cnt  <= '0;
            r_mf_pos    <= '0;
            r_loss_cnt  <= '0;
            r_cgs_done  <= 1'b0;
            r_ilas_done <= 1'b0;
            r_link_up   <= 1'b0;
        end else if (!jesd_tx_rst_n || !jesd_tx_en) begin
            r_state     <= ST_RST;
            r_cgs_cnt   <= '0;
            r_ilas_cnt  <= '0;
            r_mf_pos    <= '0;
            r_loss_cnt  <= '0;
            r_cgs_done  <= 1'b0;
            r_ilas_done <= 1'b0;
            r_link_up   <= 1'b0;
        end else begin
            case (r_state)
                ST_RST: begin
                    r_state   <= ST_CGS;
                    r_cgs_cnt <= '0;
                end
                ST_CGS: begin
                    if (r_cgs_cnt == CGS_LAST && sync_n) begin
                        r_state    <= ST_ILAS;
                        r_cgs_done <= 1'b1;
                        r_ilas_cnt <= '0;
                        r_mf_pos   <= '0;
                    end else if (r_cgs_cnt != CGS_LAST) begin
                        r_cgs_cnt <= r_cgs_cnt + 1'b1;
                    end
                end
                ST_ILAS: begin
                    if (!sync_n) begin
                        r_state     <= ST_CGS;
                        r_cgs_cnt   <= '0;
                        r_cgs_done  <= 1'b0;
                        r_ilas_done <= 1'b0;
                        r_link_up   <= 1'b0;
                    end else if (phy_rdy) begin
                        if (r_ilas_cnt == ILAS_LAST) begin
                            r_state     <= ST_DATA;
                            r_ilas_done <= 1'b1;
                            r_link_up   <= 1'b1;
                            r_loss_cnt  <= '0;
                        end else begin
                            r_ilas_cnt <= r_ilas_cnt + 1'b1;
                            r_mf_pos   <= (r_mf_pos == MF_LAST) ? '0 : r_mf_pos + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    // short SYNC~ drops only stall payload; a sustained drop forces re-sync
                    if (!sync_n) begin
                        if (r_loss_cnt == LOSS_LAST) begin
                            r_state     <= ST_CGS;
                            r_cgs_cnt   <= '0;
                            r_loss_cnt  <= '0;
                            r_cgs_done  <= 1'b0;
                            r_ilas_done <= 1'b0;
                            r_link_up   <= 1'b0;
                        end else begin
                            r_loss_cnt <= r_loss_cnt + 1'b1;
                            r_link_up  <= 1'b0;
                        end
                    end else begin
                        r_loss_cnt <= '0;
                        r_link_up  <= 1'b1;
                    end
                end
                default: r_state <= ST_RST;
            endcase
        end
    end

    always_comb begin
        phy_val     = 1'b0;
        phy_dat     = '0;
        phy_k       = '0;
        jesd_tx_rdy = 1'b0;
        case (r_state)
            ST_CGS: begin
                phy_val = 1'b1;
                for (int b = 0; b < NB; b++) phy_dat[8*b +: 8] = 8'hBC;
                phy_k   = '1;
            end
            ST_ILAS: begin
                phy_val = 1'b1;
                for (int b = 0; b < NB; b++) phy_dat[8*b +: 8] = 8'(r_ilas_cnt);
                if (r_mf_pos == '0) begin
                    phy_dat[7:0] = 8'h1C;
                    phy_k[0]     = 1'b1;
                end
                if (r_mf_pos == MF_LAST) begin
                    phy_dat[8*(NB-1) +: 8] = 8'h7C;
                    phy_k[NB-1]            = 1'b1;
                end
            end
            ST_DATA: begin
                phy_val     = 1'b1;
                jesd_tx_rdy = phy_rdy & r_link_up;
                if (jesd_tx_val && r_link_up) begin
                    phy_dat = jesd_tx_dat;
                end else begin
                    for (int b = 0; b < NB; b++) phy_dat[8*b +: 8] = 8'hFC;
                    phy_k = '1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_jesd_tx_link.sv
// Directed bench for jesd_tx_link: bring-up, ILAS content, payload ordering, SYNC~ drops,
// re-sync, async reset and link disable, checked against hand-computed lane values.
module tb_jesd_tx_link;
    localparam int P = 32;

    logic          clk = 1'b0;
    logic          rst_n, jesd_tx_rst_n, jesd_tx_en;
    logic          jesd_cgs_done, jesd_ilas_done, jesd_link_up;
    logic          jesd_tx_val, jesd_tx_rdy;
    logic [P-1:0]  jesd_tx_dat;
    logic          sync_n, phy_val, phy_rdy;
    logic [P-1:0]  phy_dat;
    logic [3:0]    phy_k;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   nxt;
    logic          exp_up;

    jesd_tx_link dut (
        .clk(clk), .rst_n(rst_n), .jesd_tx_rst_n(jesd_tx_rst_n), .jesd_tx_en(jesd_tx_en),
        .jesd_cgs_done(jesd_cgs_done), .jesd_ilas_done(jesd_ilas_done), .jesd_link_up(jesd_link_up),
        .jesd_tx_val(jesd_tx_val), .jesd_tx_rdy(jesd_tx_rdy), .jesd_tx_dat(jesd_tx_dat),
        .sync_n(sync_n), .phy_val(phy_val), .phy_rdy(phy_rdy), .phy_dat(phy_dat), .phy_k(phy_k)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] ilas_beat(input int e);
        logic [7:0]  b;
        logic [31:0] d;
        logic [3:0]  k;
        b = e[7:0];
        d = {b, b, b, b};
        k = 4'h0;
        if (e % 5 == 0) begin d[7:0]   = 8'h1C; k[0] = 1'b1; end
        if (e % 5 == 4) begin d[31:24] = 8'h7C; k[3] = 1'b1; end
        return {k, d};
    endfunction

    // entered just after the CGS-entry edge; counts edges until cgs_done
    task automatic cgs_phase(input logic rdy);
        int n;
        phy_rdy = rdy;
        sync_n  = 1'b1;
        #1;
        chk("cgs_val", phy_val, 1);
        chk("cgs_dat", phy_dat, 32'hBCBCBCBC);
        chk("cgs_k", phy_k, 4'hF);
        chk("cgs_done_lo", jesd_cgs_done, 0);
        n = 0;
        while (!jesd_cgs_done && n < 100) begin
            tick();
            n++;
        end
        chk("cgs_edges", n, 12);
    endtask

    task automatic ilas_phase(input int pct);
        int e, cyc;
        logic [35:0] x;
        e = 0;
        cyc = 0;
        while (!jesd_ilas_done && cyc < 500) begin
            phy_rdy = ($urandom_range(99) < pct);
            #1;
            x = ilas_beat(e);
            chk("ilas_dat", phy_dat, x[31:0]);
            chk("ilas_k", phy_k, x[35:32]);
            chk("ilas_tx_rdy", jesd_tx_rdy, 0);
            if (phy_rdy) e++;
            tick();
            cyc++;
        end
        chk("ilas_beats", e, 20);
        chk("ilas_link_up", jesd_link_up, 1);
        chk("ilas_cgs_done", jesd_cgs_done, 1);
        exp_up = 1'b1;
    endtask

    task automatic data_cycle(input logic v, input logic r, input logic sn);
        jesd_tx_val = v;
        jesd_tx_dat = nxt;
        phy_rdy     = r;
        sync_n      = sn;
        #1;
        chk("data_val", phy_val, 1);
        chk("data_up", jesd_link_up, exp_up);
        chk("data_rdy", jesd_tx_rdy, r & exp_up);
        if (v && exp_up) begin
            chk("data_dat", phy_dat, nxt);
            chk("data_k", phy_k, 4'h0);
        end else begin
            chk("fill_dat", phy_dat, 32'hFCFCFCFC);
            chk("fill_k", phy_k, 4'hF);
        end
        if (v && r && exp_up) nxt++;
        tick();
        exp_up = sn;
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; jesd_tx_rst_n = 1'b0; jesd_tx_en = 1'b0;
        jesd_tx_val = 1'b0; jesd_tx_dat = '0; sync_n = 1'b1; phy_rdy = 1'b1;
        exp_up = 1'b0; nxt = 32'h1000;
        #2;
        chk("rst_val", phy_val, 0);
        chk("rst_dat", phy_dat, 0);
        chk("rst_k", phy_k, 0);
        chk("rst_status", {jesd_cgs_done, jesd_ilas_done, jesd_link_up}, 0);
        chk("rst_tx_rdy", jesd_tx_rdy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_hold_val", phy_val, 0);

        // bring-up with PHY always ready
        jesd_tx_rst_n = 1'b1; jesd_tx_en = 1'b1;
        tick();
        cgs_phase(1'b1);
        ilas_phase(100);
        repeat (5) data_cycle(1'b1, 1'b1, 1'b1);

        // async reset mid-DATA
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_val", phy_val, 0);
        chk("arst_dat", phy_dat, 0);
        chk("arst_k", phy_k, 0);
        chk("arst_status", {jesd_cgs_done, jesd_ilas_done, jesd_link_up}, 0);
        chk("arst_tx_rdy", jesd_tx_rdy, 0);
        tick();
        rst_n = 1'b1;
        jesd_tx_val = 1'b0;
        tick();
        cgs_phase(1'b1);
        ilas_phase(75);

        // 500 counted beats with random valid and backpressure
        nxt = 32'h1000;
        cyc = 0;
        while (nxt < 32'h1000 + 500 && cyc < 5000) begin
            data_cycle($urandom_range(99) < 70, $urandom_range(99) < 75, 1'b1);
            cyc++;
        end
        chk("t4_count", nxt, 32'h1000 + 500);

        // short SYNC~ drops: stall only
        for (int d = 1; d <= 3; d++) begin
            repeat (2) data_cycle(1'b1, 1'b1, 1'b1);
            repeat (d) data_cycle(1'b1, 1'b1, 1'b0);
            repeat (3) data_cycle(1'b1, 1'b1, 1'b1);
            chk("t5_no_resync", {jesd_cgs_done, jesd_ilas_done}, 2'b11);
        end

        // sustained drop: re-sync, CGS counts with PHY stalled
        repeat (4) data_cycle(1'b1, 1'b1, 1'b0);
        chk("t6_status", {jesd_cgs_done, jesd_ilas_done, jesd_link_up}, 0);
        chk("t6_cgs_dat", phy_dat, 32'hBCBCBCBC);
        cgs_phase(1'b0);

        // SYNC~ drop during ILAS aborts back to CGS
        phy_rdy = 1'b1;
        repeat (3) tick();
        sync_n = 1'b0;
        tick();
        chk("ilas_abort_status", {jesd_cgs_done, jesd_ilas_done, jesd_link_up}, 0);
        chk("ilas_abort_dat", phy_dat, 32'hBCBCBCBC);
        cgs_phase(1'b1);
        ilas_phase(100);
        repeat (3) data_cycle(1'b1, 1'b1, 1'b1);

        // link disable from DATA
        jesd_tx_en = 1'b0;
        tick();
        chk("dis_val", phy_val, 0);
        chk("dis_status", {jesd_cgs_done, jesd_ilas_done, jesd_link_up}, 0);
        chk("dis_tx_rdy", jesd_tx_rdy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
